// File: rtl/i2s_stereo_capture.sv
// rtl/i2s_stereo_capture.sv - I2S master receiver: SCK/WS generation and sample capture
//
// Generates SCK and WS for an I2S MEMS microphone, deserialises the data
// line and hands finished samples to a valid/ready stream. Supports stereo,
// left-only, right-only and mono (average of L and R) capture.
//
// Ports:
//   i_clk, i_rst        system clock, asynchronous active-high reset
//   i_enable            1 = run the interface, 0 = idle with SCK/WS low
//   i_mode              00 stereo, 01 left, 10 right, 11 mono (L+R)/2
//   o_i2s_clk           SCK to the mic
//   o_i2s_ws            word select, 0 = left slot, 1 = right slot
//   i_i2s_sd            serial data from the mic (asynchronous)
//   o_sample_data       captured sample, signed, DATA_SIZE bits
//   o_sample_channel    0 = left or mono, 1 = right
//   o_sample_valid      stream valid; accepted when valid and ready
//   i_sample_ready      stream ready
//   o_overflow          sticky flag: a sample was dropped
//   i_overflow_clr      clears o_overflow (a new drop wins)
module i2s_stereo_capture #(
   parameter int DATA_SIZE    = 24,
   parameter int SLOT_BITS    = 32,
   parameter int CLK_FREQ     = 100_000_000,
   parameter int I2S_CLK_FREQ = 1_500_000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic [1:0]           i_mode,
   output logic                 o_i2s_clk,
   output logic                 o_i2s_ws,
   input  logic                 i_i2s_sd,
   output logic [DATA_SIZE-1:0] o_sample_data,
   output logic                 o_sample_channel,
   output logic                 o_sample_valid,
   input  logic                 i_sample_ready,
   output logic                 o_overflow,
   input  logic                 i_overflow_clr
);
   localparam int CLK_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int FRAME   = 2 * SLOT_BITS;
   localparam int BC_W    = $clog2(FRAME);

   logic [DIV_W-1:0]     r_div;
   logic                 r_sck;
   logic                 r_ws;
   logic [BC_W-1:0]      r_bc;
   logic                 r_sd_meta;
   logic                 r_sd_sync;
   logic [DATA_SIZE-1:0] r_shift;
   logic [1:0]           r_mode;
   logic                 r_fresh;
   logic [DATA_SIZE-1:0] r_left_hold;
   logic                 r_left_ok;
   logic [DATA_SIZE-1:0] r_data;
   logic                 r_chan;
   logic                 r_valid;
   logic                 r_ovf;

   logic                 w_wrap;
   logic                 w_rise;
   logic                 w_fall;
   logic                 w_right;
   logic [BC_W-1:0]      w_slot;
   logic                 w_bc_last;
   logic [BC_W-1:0]      w_bc_next;
   logic [DATA_SIZE-1:0] w_word;
   logic                 w_done;
   logic signed [DATA_SIZE:0] w_sum;
   logic [DATA_SIZE-1:0] w_avg;
   logic                 w_emit;
   logic [DATA_SIZE-1:0] w_emit_data;
   logic                 w_emit_chan;
   logic                 w_accept;

   assign w_wrap    = i_enable && (r_div == DIV_W'(CLK_DIV - 1));
   assign w_rise    = w_wrap && !r_sck;
   assign w_fall    = w_wrap && r_sck;
   assign w_right   = (r_bc >= BC_W'(SLOT_BITS));
   assign w_slot    = w_right ? (r_bc - BC_W'(SLOT_BITS)) : r_bc;
   assign w_bc_last = (r_bc == BC_W'(FRAME - 1));
   assign w_bc_next = w_bc_last ? '0 : r_bc + 1'b1;
   // Shift register contents including the bit arriving on this rise.
   assign w_word    = (r_shift << 1) | DATA_SIZE'(r_sd_sync);
   assign w_done    = w_rise && (w_slot == BC_W'(DATA_SIZE));
   // One extra bit of headroom so full-scale L+R cannot wrap.
   assign w_sum     = $signed({r_left_hold[DATA_SIZE-1], r_left_hold})
                    + $signed({w_word[DATA_SIZE-1], w_word});
   assign w_avg     = DATA_SIZE'(w_sum >>> 1);
   assign w_accept  = r_valid && i_sample_ready;

   always_comb begin
      w_emit      = 1'b0;
      w_emit_data = w_word;
      w_emit_chan = w_right;
      if (w_done) begin
         case (r_mode)
            2'b00: w_emit = 1'b1;
            2'b01: w_emit = !w_right;
            2'b10: w_emit = w_right;
            default: begin
               if (w_right && r_left_ok) begin
                  w_emit      = 1'b1;
                  w_emit_data = w_avg;
                  w_emit_chan = 1'b0;
               end
            end
         endcase
      end
   end

   // SCK divider, bit counter and word select
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div <= '0;
         r_sck <= 1'b0;
         r_bc  <= '0;
         r_ws  <= 1'b0;
      end else if (!i_enable) begin
         r_div <= '0;
         r_sck <= 1'b0;
         r_bc  <= '0;
         r_ws  <= 1'b0;
      end else begin
         if (w_wrap) begin
            r_div <= '0;
            r_sck <= !r_sck;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (w_fall) begin
            r_bc <= w_bc_next;
            r_ws <= (w_bc_next >= BC_W'(SLOT_BITS));
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sd_meta <= 1'b0;
         r_sd_sync <= 1'b0;
      end else begin
         r_sd_meta <= i_i2s_sd;
         r_sd_sync <= r_sd_meta;
      end
   end

   // Capture path: shift register, mode latch and mono left hold.
   // r_fresh makes the first enabled cycle after idle/reset act as a frame start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shift     <= '0;
         r_mode      <= 2'b00;
         r_fresh     <= 1'b1;
         r_left_hold <= '0;
         r_left_ok   <= 1'b0;
      end else if (!i_enable) begin
         r_shift     <= '0;
         r_fresh     <= 1'b1;
         r_left_hold <= '0;
         r_left_ok   <= 1'b0;
      end else begin
         if (r_fresh) begin
            r_mode  <= i_mode;
            r_fresh <= 1'b0;
         end else if (w_fall && w_bc_last) begin
            r_mode    <= i_mode;
            r_left_ok <= 1'b0;
         end
         if (w_rise) begin
            if (w_slot == '0) begin
               r_shift <= '0;
            end else if (w_slot <= BC_W'(DATA_SIZE)) begin
               r_shift <= w_word;
            end
         end
         if (w_done && (r_mode == 2'b11)) begin
            if (!w_right) begin
               r_left_hold <= w_word;
               r_left_ok   <= 1'b1;
            end else begin
               r_left_ok   <= 1'b0;
            end
         end
      end
   end

   // Output stream; a pending sample survives enable going low.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data  <= '0;
         r_chan  <= 1'b0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_emit && (!r_valid || w_accept)) begin
            r_data  <= w_emit_data;
            r_chan  <= w_emit_chan;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
         if (w_emit && r_valid && !w_accept) begin
            r_ovf <= 1'b1;
         end else if (i_overflow_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign o_i2s_clk        = r_sck;
   assign o_i2s_ws         = r_ws;
   assign o_sample_data    = r_data;
   assign o_sample_channel = r_chan;
   assign o_sample_valid   = r_valid;
   assign o_overflow       = r_ovf;

endmodule

// File: tb/tb_i2s_stereo_capture.sv
// tb/tb_i2s_stereo_capture.sv - bench for i2s_stereo_capture
`timescale 1ns/1ps
module tb_i2s_stereo_capture;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en1, en2, ready1, ready2, clr1, clr2, sd1, sd2;
   logic [1:0] mode1, mode2;
   logic sck1, ws1, ch1, v1, ov1;
   logic sck2, ws2, ch2, v2, ov2;
   logic [23:0] d1;
   logic [11:0] d2;
   int total = 0;
   int bad = 0;
   logic [23:0] mic_l1, mic_r1;
   logic [11:0] mic_l2, mic_r2;
   logic [24:0] exp1[$];
   logic [12:0] exp2[$];
   logic [24:0] e1;
   logic [12:0] e2;

   i2s_stereo_capture dut1 (
      .i_clk(clk), .i_rst(rst), .i_enable(en1), .i_mode(mode1),
      .o_i2s_clk(sck1), .o_i2s_ws(ws1), .i_i2s_sd(sd1),
      .o_sample_data(d1), .o_sample_channel(ch1), .o_sample_valid(v1),
      .i_sample_ready(ready1), .o_overflow(ov1), .i_overflow_clr(clr1));

   i2s_stereo_capture #(.DATA_SIZE(12), .SLOT_BITS(16), .CLK_FREQ(100_000_000),
                        .I2S_CLK_FREQ(12_500_000)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_mode(mode2),
      .o_i2s_clk(sck2), .o_i2s_ws(ws2), .i_i2s_sd(sd2),
      .o_sample_data(d2), .o_sample_channel(ch2), .o_sample_valid(v2),
      .i_sample_ready(ready2), .o_overflow(ov2), .i_overflow_clr(clr2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Mono rule: signed average, arithmetic shift of the full-precision sum.
   function automatic logic [23:0] avg24(input logic [23:0] l, input logic [23:0] r);
      int sl, sr, s;
      sl = {{8{l[23]}}, l};
      sr = {{8{r[23]}}, r};
      s = (sl + sr) >>> 1;
      return s[23:0];
   endfunction

   task automatic model_frame1(input logic [1:0] m, input logic [23:0] l, input logic [23:0] r);
      case (m)
         2'b00: begin exp1.push_back({1'b0, l}); exp1.push_back({1'b1, r}); end
         2'b01: exp1.push_back({1'b0, l});
         2'b10: exp1.push_back({1'b1, r});
         default: exp1.push_back({1'b0, avg24(l, r)});
      endcase
   endtask

   // Mic models: a WS change restarts the slot; bit 0 is the I2S delay bit,
   // bits 1..N carry the word MSB first, everything else is noise.
   int k1, k2;
   logic wsp1, sckp1, wsp2, sckp2;
   always @(negedge clk) begin
      if (rst || !en1) begin
         k1 = 0; wsp1 = 1'b0;
      end else if (sckp1 && !sck1) begin
         if (ws1 != wsp1) k1 = 0; else k1++;
         wsp1 = ws1;
         if (k1 >= 1 && k1 <= 24) sd1 = ws1 ? mic_r1[24-k1] : mic_l1[24-k1];
         else sd1 = 1'($urandom);
      end
      sckp1 = sck1;
   end
   always @(negedge clk) begin
      if (rst || !en2) begin
         k2 = 0; wsp2 = 1'b0;
      end else if (sckp2 && !sck2) begin
         if (ws2 != wsp2) k2 = 0; else k2++;
         wsp2 = ws2;
         if (k2 >= 1 && k2 <= 12) sd2 = ws2 ? mic_r2[12-k2] : mic_l2[12-k2];
         else sd2 = 1'($urandom);
      end
      sckp2 = sck2;
   end

   // Frame length and WS-changes-on-SCK-fall monitors
   int rises1, rises2;
   logic wsm1, sckm1, enm1, wsm2, sckm2, enm2;
   always @(negedge clk) begin
      if (rst || !en1) rises1 = 0;
      else begin
         if (!sckm1 && sck1) rises1++;
         if (wsm1 && !ws1) begin check("frame_sck1", rises1, 64); rises1 = 0; end
         if (enm1 && ws1 != wsm1) check("ws_on_fall1", {sckm1, sck1}, 2'b10);
      end
      wsm1 = ws1; sckm1 = sck1; enm1 = en1 && !rst;
   end
   always @(negedge clk) begin
      if (rst || !en2) rises2 = 0;
      else begin
         if (!sckm2 && sck2) rises2++;
         if (wsm2 && !ws2) begin check("frame_sck2", rises2, 32); rises2 = 0; end
         if (enm2 && ws2 != wsm2) check("ws_on_fall2", {sckm2, sck2}, 2'b10);
      end
      wsm2 = ws2; sckm2 = sck2; enm2 = en2 && !rst;
   end

   // Stream compare against the model queues
   logic hold1, hc1, hold2, hc2;
   logic [23:0] hd1;
   logic [11:0] hd2;
   always @(negedge clk) begin
      if (rst) hold1 = 1'b0;
      else begin
         if (hold1) begin
            check("hold_valid1", v1, 1);
            check("hold_data1", d1, hd1);
            check("hold_chan1", ch1, hc1);
         end
         if (v1 && ready1) begin
            if (exp1.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_sample1: got %0h ch %0d want none", d1, ch1);
            end else begin
               e1 = exp1.pop_front();
               check("data1", d1, e1[23:0]);
               check("chan1", ch1, e1[24]);
            end
         end
         hold1 = v1 && !ready1; hd1 = d1; hc1 = ch1;
      end
   end
   always @(negedge clk) begin
      if (rst) hold2 = 1'b0;
      else begin
         if (hold2) begin
            check("hold_valid2", v2, 1);
            check("hold_data2", d2, hd2);
         end
         if (v2 && ready2) begin
            if (exp2.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_sample2: got %0h ch %0d want none", d2, ch2);
            end else begin
               e2 = exp2.pop_front();
               check("data2", d2, e2[11:0]);
               check("chan2", ch2, e2[12]);
            end
         end
         hold2 = v2 && !ready2; hd2 = d2; hc2 = ch2;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = WS fall, 1 = WS rise, 2 = SCK fall
   task automatic wait_evt(input int sel, input int kind, input int n, input int budget);
      int cnt;
      logic pws, psck, cws, csck;
      cnt = 0;
      pws = sel ? ws2 : ws1;
      psck = sel ? sck2 : sck1;
      for (int i = 0; i < budget && cnt < n; i++) begin
         tick();
         cws = sel ? ws2 : ws1;
         csck = sel ? sck2 : sck1;
         case (kind)
            0: if (pws && !cws) cnt++;
            1: if (!pws && cws) cnt++;
            default: if (psck && !csck) cnt++;
         endcase
         pws = cws; psck = csck;
      end
      if (cnt < n) begin
         total++; bad++;
         $display("FAIL timeout sel=%0d kind=%0d: got %0d events want %0d", sel, kind, cnt, n);
      end
   endtask

   task automatic drain1(input string name);
      repeat (10) tick();
      check(name, exp1.size(), 0);
      check({name, "_sck"}, sck1, 0);
      check({name, "_ws"}, ws1, 0);
   endtask

   initial begin
      rst = 1'b1; en1 = 1'b0; en2 = 1'b0; ready1 = 1'b1; ready2 = 1'b1;
      clr1 = 1'b0; clr2 = 1'b0; sd1 = 1'b0; sd2 = 1'b0; mode1 = 2'b00; mode2 = 2'b00;
      mic_l1 = '0; mic_r1 = '0; mic_l2 = '0; mic_r2 = '0;
      repeat (3) tick();
      check("rst_sck", sck1, 0);
      check("rst_ws", ws1, 0);
      check("rst_data", d1, 0);
      check("rst_chan", ch1, 0);
      check("rst_valid", v1, 0);
      check("rst_ovf", ov1, 0);
      check("rst_valid2", v2, 0);
      rst = 1'b0;
      tick();

      check("avg_pin_a", avg24(24'h000010, 24'hFFFFF0), 24'h000000);
      check("avg_pin_b", avg24(24'h7FFFFF, 24'h7FFFFF), 24'h7FFFFF);
      check("avg_pin_c", avg24(24'h800000, 24'h800000), 24'h800000);
      check("avg_pin_d", avg24(24'hFFFFFF, 24'h000000), 24'hFFFFFF);

      // stereo
      mode1 = 2'b00; mic_l1 = 24'h123456; mic_r1 = 24'hFEDCBA;
      model_frame1(2'b00, mic_l1, mic_r1);
      en1 = 1'b1;
      wait_evt(0, 0, 1, 5000);
      en1 = 1'b0;
      drain1("t1_drain");

      // mono
      mode1 = 2'b11; mic_l1 = 24'h000010; mic_r1 = 24'hFFFFF0;
      exp1.push_back({1'b0, 24'h000000});
      en1 = 1'b1;
      wait_evt(0, 0, 1, 5000);
      mic_l1 = 24'h7FFFFF; mic_r1 = 24'h7FFFFF;
      model_frame1(2'b11, mic_l1, mic_r1);
      wait_evt(0, 0, 1, 5000);
      en1 = 1'b0;
      drain1("t2_drain");
      check("t2_ovf", ov1, 0);

      // left only, switched to right only mid-frame
      mode1 = 2'b01; mic_l1 = 24'h0A0B0C; mic_r1 = 24'h0D0E0F;
      exp1.push_back({1'b0, 24'h0A0B0C});
      exp1.push_back({1'b1, 24'h0D0E0F});
      en1 = 1'b1;
      wait_evt(0, 1, 1, 5000);
      mode1 = 2'b10;
      wait_evt(0, 0, 2, 9000);
      en1 = 1'b0;
      drain1("t3_drain");

      // backpressure for three slot completions
      mode1 = 2'b00; ready1 = 1'b0; mic_l1 = 24'h111111; mic_r1 = 24'h222222;
      exp1.push_back({1'b0, 24'h111111});
      exp1.push_back({1'b1, 24'h444444});
      en1 = 1'b1;
      wait_evt(0, 0, 1, 5000);
      mic_l1 = 24'h333333; mic_r1 = 24'h444444;
      wait_evt(0, 1, 1, 5000);
      check("t4_ovf_set", ov1, 1);
      check("t4_held_data", d1, 24'h111111);
      ready1 = 1'b1;
      wait_evt(0, 0, 1, 5000);
      en1 = 1'b0;
      drain1("t4_drain");
      check("t4_ovf_sticky", ov1, 1);
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      tick();
      check("t4_ovf_clr", ov1, 0);

      // disable at bc=20, nothing emitted
      mode1 = 2'b00; mic_l1 = 24'h0F0F0F; mic_r1 = 24'h707070;
      en1 = 1'b1;
      wait_evt(0, 2, 20, 2000);
      en1 = 1'b0;
      repeat (3) tick();
      check("t6_dis_sck", sck1, 0);
      check("t6_dis_ws", ws1, 0);
      check("t6_dis_valid", v1, 0);
      // async reset at bc=40: left already out, right discarded
      exp1.push_back({1'b0, 24'h0F0F0F});
      en1 = 1'b1;
      wait_evt(0, 2, 40, 4000);
      check("t6_ws_before_rst", ws1, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_sck", sck1, 0);
      check("t6_rst_ws", ws1, 0);
      check("t6_rst_valid", v1, 0);
      check("t6_rst_data", d1, 0);
      en1 = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("t6_rst_drain", exp1.size(), 0);
      mode1 = 2'b01; mic_l1 = 24'h13579B; mic_r1 = 24'h2468AC;
      exp1.push_back({1'b0, 24'h13579B});
      en1 = 1'b1;
      wait_evt(0, 0, 1, 5000);
      en1 = 1'b0;
      drain1("t6_restart_drain");

      // 16-bit slots, 12-bit samples
      mode2 = 2'b00; mic_l2 = 12'hABC; mic_r2 = 12'h5A3;
      exp2.push_back({1'b0, 12'hABC});
      exp2.push_back({1'b1, 12'h5A3});
      exp2.push_back({1'b0, 12'h800});
      exp2.push_back({1'b1, 12'h7FF});
      en2 = 1'b1;
      wait_evt(1, 0, 1, 400);
      mic_l2 = 12'h800; mic_r2 = 12'h7FF;
      wait_evt(1, 0, 1, 400);
      en2 = 1'b0;
      repeat (10) tick();
      check("t5_drain", exp2.size(), 0);
      check("t5_sck_idle", sck2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
